// File: rtl/multi_mode_counter_bank_if.sv
// Control/data bundle for multi_mode_counter_bank.
// The bench drives through master; the counter bank receives it through slave.
interface multi_mode_counter_bank_if #(
  parameter int CH = 4
);
  logic            ce;
  logic [1:0]      mode;
  logic            up;
  logic            chain;
  logic            L;
  logic [4*CH-1:0] di;
  logic [4*CH-1:0] Q;
  logic [CH-1:0]   TC;
  logic            CEO;
  logic            ovf;

  modport master (
    output ce, mode, up, chain, L, di,
    input  Q, TC, CEO, ovf
  );

  modport slave (
    input  ce, mode, up, chain, L, di,
    output Q, TC, CEO, ovf
  );
endinterface

// File: rtl/multi_mode_counter_bank.sv
// Bank of CH 4-bit digit counters: binary mod-M, BCD, Johnson or Gray, up or down.
// Digits count in parallel or as one ripple-cascaded number; latency 1 cycle, no backpressure.
module multi_mode_counter_bank #(
  parameter int CH = 4,
  parameter int M  = 12
) (
  input  logic clk,
  input  logic clr,
  multi_mode_counter_bank_if.slave bus
);

  localparam logic [3:0] BMAX = 4'(M - 1);

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_BCD  = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;

  logic [4*CH-1:0] q_r;
  logic            ovf_r;
  logic [CH-1:0]   tc;
  logic [CH-1:0]   en;
  logic            ceo;

  function automatic logic is_legal(input logic [1:0] md, input logic [3:0] v);
    logic ok;
    ok = 1'b1;
    case (md)
      MODE_BIN:  ok = (v <= BMAX);
      MODE_BCD:  ok = (v <= 4'd9);
      MODE_JOHN: ok = (v inside {4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                 4'b1111, 4'b1110, 4'b1100, 4'b1000});
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] term_val(input logic [1:0] md, input logic dir);
    logic [3:0] t;
    t = 4'b0000;
    if (dir) begin
      case (md)
        MODE_BIN: t = BMAX;
        MODE_BCD: t = 4'd9;
        default:  t = 4'b1000;
      endcase
    end
    return t;
  endfunction

  // Wrap at both ends is folded into the step so callers only gate legality.
  function automatic logic [3:0] step(input logic [1:0] md, input logic dir,
                                      input logic [3:0] v);
    logic [3:0] n;
    logic [3:0] b;
    n = 4'b0000;
    b = 4'b0000;
    case (md)
      MODE_BIN: begin
        if (dir) n = (v == BMAX)  ? 4'd0 : v + 4'd1;
        else     n = (v == 4'd0)  ? BMAX : v - 4'd1;
      end
      MODE_BCD: begin
        if (dir) n = (v == 4'd9)  ? 4'd0 : v + 4'd1;
        else     n = (v == 4'd0)  ? 4'd9 : v - 4'd1;
      end
      MODE_JOHN: begin
        if (dir) n = {v[2:0], ~v[3]};
        else     n = {~v[0], v[3:1]};
      end
      default: begin
        b[3] = v[3];
        b[2] = b[3] ^ v[2];
        b[1] = b[2] ^ v[1];
        b[0] = b[1] ^ v[0];
        b    = dir ? b + 4'd1 : b - 4'd1;
        n    = b ^ {1'b0, b[3:1]};
      end
    endcase
    return n;
  endfunction

  always_comb begin
    tc = '0;
    for (int i = 0; i < CH; i++) begin
      tc[i] = is_legal(bus.mode, q_r[4*i +: 4]) &&
              (q_r[4*i +: 4] == term_val(bus.mode, bus.up));
    end
  end

  // In cascade mode a digit advances only when every lower digit is terminal.
  always_comb begin
    logic run;
    run = bus.ce;
    en  = '0;
    for (int i = 0; i < CH; i++) begin
      en[i] = bus.chain ? run : bus.ce;
      run   = run & tc[i];
    end
  end

  assign ceo = bus.ce & (bus.chain ? (&tc) : (|tc));

  always_ff @(posedge clk) begin
    if (clr) begin
      q_r   <= '0;
      ovf_r <= 1'b0;
    end else if (bus.L) begin
      q_r   <= bus.di;
      ovf_r <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (en[i]) begin
          q_r[4*i +: 4] <= is_legal(bus.mode, q_r[4*i +: 4]) ?
                           step(bus.mode, bus.up, q_r[4*i +: 4]) : 4'b0000;
        end
      end
      ovf_r <= ovf_r | ceo;
    end
  end

  assign bus.Q   = q_r;
  assign bus.TC  = tc;
  assign bus.CEO = ceo;
  assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_multi_mode_counter_bank.sv
// Directed bench: a 4-digit bank and a 1-digit bank (Gray walk) driven in lockstep.
module tb_multi_mode_counter_bank;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string      tag;
    bit         sel;
    logic [15:0] q;
  } exp_t;
  exp_t sb[$];

  multi_mode_counter_bank_if #(.CH(4)) if4 ();
  multi_mode_counter_bank_if #(.CH(1)) if1 ();

  assign if1.ce    = if4.ce;
  assign if1.mode  = if4.mode;
  assign if1.up    = if4.up;
  assign if1.chain = if4.chain;
  assign if1.L     = if4.L;
  assign if1.di    = if4.di[3:0];

  multi_mode_counter_bank #(.CH(4), .M(12)) dut4 (.clk(clk), .clr(clr), .bus(if4.slave));
  multi_mode_counter_bank #(.CH(1), .M(12)) dut1 (.clk(clk), .clr(clr), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_q(input string tag, input bit sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.q   = v;
    sb.push_back(e);
  endtask

  task automatic pop_q();
    exp_t e;
    logic [15:0] obs;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e   = sb.pop_front();
      obs = e.sel ? {12'h000, if1.Q} : if4.Q;
      chk(e.tag, obs, e.q);
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] kb;

    if4.ce = 1'b0; if4.mode = 2'b00; if4.up = 1'b1; if4.chain = 1'b0;
    if4.L = 1'b0;  if4.di = 16'h0000;

    // reset state, binary up
    clr = 1'b1; tick(); clr = 1'b0;
    push_q("reset_q", 1'b0, 16'h0000); pop_q();
    chk("reset_ovf", {15'b0, if4.ovf}, 16'h0000);
    chk("reset_tc_up", {12'b0, if4.TC}, 16'h0000);
    chk("reset_ceo", {15'b0, if4.CEO}, 16'h0000);

    // BCD cascade up: 1234 ticks, then full wrap from 9999
    if4.mode = 2'b01; if4.chain = 1'b1; if4.up = 1'b1;
    push_q("bcd_1234", 1'b0, 16'h1234);
    if4.ce = 1'b1; repeat (1234) tick(); if4.ce = 1'b0;
    pop_q();
    chk("bcd_1234_ovf", {15'b0, if4.ovf}, 16'h0000);
    if4.L = 1'b1; if4.di = 16'h9999; tick(); if4.L = 1'b0;
    push_q("bcd_load_9999", 1'b0, 16'h9999); pop_q();
    if4.ce = 1'b1; #1;
    chk("bcd_wrap_ceo", {15'b0, if4.CEO}, 16'h0001);
    tick(); if4.ce = 1'b0;
    push_q("bcd_wrap_q", 1'b0, 16'h0000); pop_q();
    chk("bcd_wrap_ovf", {15'b0, if4.ovf}, 16'h0001);

    // binary mod 12, parallel digits
    clr = 1'b1; tick(); clr = 1'b0;
    if4.mode = 2'b00; if4.chain = 1'b0; if4.up = 1'b1; if4.ce = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      kb = 4'(k % 12);
      push_q("bin_step", 1'b0, {4{kb}}); pop_q();
      if (k == 11) begin
        chk("bin_tc_bbbb", {12'b0, if4.TC}, 16'h000F);
        chk("bin_ceo_bbbb", {15'b0, if4.CEO}, 16'h0001);
      end
    end
    if4.ce = 1'b0;
    chk("bin_ovf", {15'b0, if4.ovf}, 16'h0001);

    // Johnson cascade down from reset
    clr = 1'b1; tick(); clr = 1'b0;
    if4.mode = 2'b10; if4.chain = 1'b1; if4.up = 1'b0; #1;
    chk("john_tc_down", {12'b0, if4.TC}, 16'h000F);
    if4.ce = 1'b1; #1;
    chk("john_ceo", {15'b0, if4.CEO}, 16'h0001);
    tick();
    push_q("john_8888", 1'b0, 16'h8888); pop_q();
    chk("john_ovf", {15'b0, if4.ovf}, 16'h0001);
    tick(); if4.ce = 1'b0;
    push_q("john_888c", 1'b0, 16'h888C); pop_q();
    chk("john_ovf_sticky", {15'b0, if4.ovf}, 16'h0001);

    // BCD parallel with illegal loaded digits
    if4.mode = 2'b01; if4.chain = 1'b0; if4.up = 1'b1;
    if4.L = 1'b1; if4.di = 16'hFA3C; tick(); if4.L = 1'b0;
    push_q("bcd_load_fa3c", 1'b0, 16'hFA3C); pop_q();
    chk("bcd_illegal_tc", {12'b0, if4.TC}, 16'h0000);
    chk("load_clears_ovf", {15'b0, if4.ovf}, 16'h0000);
    if4.ce = 1'b1; tick(); if4.ce = 1'b0;
    push_q("bcd_illegal_q", 1'b0, 16'h0040); pop_q();

    // Gray walk on the 1-digit bank
    clr = 1'b1; tick(); clr = 1'b0;
    if4.mode = 2'b11; if4.chain = 1'b0; if4.up = 1'b1; if4.ce = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      kb = 4'(k % 16);
      g  = kb ^ (kb >> 1);
      push_q("gray_step", 1'b1, {12'h000, g}); pop_q();
      chk("gray_tc", {15'b0, if1.TC}, (g == 4'h8) ? 16'h0001 : 16'h0000);
    end
    if4.ce = 1'b0;
    chk("gray_ovf", {15'b0, if1.ovf}, 16'h0001);

    // priority: clr > L > count
    if4.mode = 2'b01; if4.chain = 1'b0; if4.up = 1'b1;
    clr = 1'b1; if4.L = 1'b1; if4.ce = 1'b1; if4.di = 16'h0505; tick(); clr = 1'b0;
    push_q("prio_clr", 1'b0, 16'h0000); pop_q();
    chk("prio_clr_ovf", {15'b0, if4.ovf}, 16'h0000);
    tick();
    push_q("prio_load", 1'b0, 16'h0505); pop_q();
    if4.di = 16'h0909; tick(); if4.L = 1'b0;
    push_q("prio_load_0909", 1'b0, 16'h0909); pop_q();
    tick(); if4.ce = 1'b0;
    push_q("bcd_par_wrap", 1'b0, 16'h1010); pop_q();
    chk("par_ovf_set", {15'b0, if4.ovf}, 16'h0001);
    if4.L = 1'b1; if4.di = 16'h0000; tick(); if4.L = 1'b0;
    chk("load_ovf_clear", {15'b0, if4.ovf}, 16'h0000);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
